// File: rtl/sum_req_host_if.sv
// Request/response link between the sum requester and the summation engine:
// the requester presents N with a one-cycle strobe, the engine answers with sum.
interface sum_req_host_if #(
  parameter int N_W   = 8,
  parameter int SUM_W = 16
);
  logic [N_W-1:0]   N;
  logic             N_valid;
  logic [SUM_W-1:0] sum;
  logic             sum_valid;

  modport master (
    output N,
    output N_valid,
    input  sum,
    input  sum_valid
  );

  modport slave (
    input  N,
    input  N_valid,
    output sum,
    output sum_valid
  );
endinterface

// File: rtl/sum_req_host.sv
// Issues a programmed run of consecutive N values to the summation engine,
// checks each returned sum against N*(N+1)/2 and keeps pass/fail/error stats.
module sum_req_host #(
  parameter int N_W         = 8,
  parameter int SUM_W       = 16,
  parameter int CNT_W       = 8,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [N_W-1:0]   n_first,
  input  logic [CNT_W-1:0] n_count,
  sum_req_host_if.master   eng,
  output logic             busy,
  output logic             run_done,
  output logic [SUM_W-1:0] last_sum,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             timeout_err,
  output logic             proto_err
);

  localparam int TO_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ISSUE  = 3'd1;
  localparam logic [2:0] WAIT   = 3'd2;
  localparam logic [2:0] GAP    = 3'd3;
  localparam logic [2:0] FINISH = 3'd4;

  // Closed-form expected sum, evaluated wide enough that N*(N+1) never overflows.
  function automatic logic [SUM_W-1:0] calc_exp(input logic [N_W-1:0] n);
    logic [2*N_W:0] wide;
    logic [2*N_W:0] prod;
    wide = {{(N_W+1){1'b0}}, n};
    prod = wide * (wide + 1'b1);
    return SUM_W'(prod >> 1);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [N_W-1:0]   n_q;
  logic             nvalid_q;
  logic [CNT_W-1:0] rem_q;
  logic [TO_W-1:0]  tcnt_q;

  logic take_start;
  logic take_sum;
  logic stray_sum;
  logic to_hit;
  logic sum_ok;

  assign take_start = (state == IDLE) && start;
  assign take_sum   = (state == WAIT) && eng.sum_valid;
  assign stray_sum  = (state != WAIT) && eng.sum_valid;
  assign to_hit     = (state == WAIT) && !eng.sum_valid && (tcnt_q == TO_LAST);
  assign sum_ok     = (eng.sum == calc_exp(n_q));

  assign eng.N       = n_q;
  assign eng.N_valid = nvalid_q;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (n_count != '0) ? ISSUE : FINISH;
      ISSUE:   state_nxt = WAIT;
      WAIT: begin
        if (eng.sum_valid)        state_nxt = GAP;
        else if (tcnt_q == TO_LAST) state_nxt = FINISH;
      end
      GAP:     state_nxt = (rem_q == '0) ? FINISH : ISSUE;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes are registered decodes of the state just left, so N_valid lands
  // in the first WAIT cycle and run_done in the cycle after FINISH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      nvalid_q <= 1'b0;
      run_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      busy     <= (state_nxt != IDLE);
      nvalid_q <= (state == ISSUE);
      run_done <= (state == FINISH);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      n_q    <= '0;
      rem_q  <= '0;
      tcnt_q <= '0;
    end else begin
      if (take_start) begin
        n_q   <= n_first;
        rem_q <= n_count;
      end
      if (state == ISSUE) tcnt_q <= '0;
      else if (state == WAIT && !eng.sum_valid && !to_hit) tcnt_q <= tcnt_q + 1'b1;
      if (take_sum) rem_q <= rem_q - 1'b1;
      if (state == GAP && rem_q != '0) n_q <= n_q + 1'b1;
    end
  end

  // Result capture and run statistics; a stray strobe only raises proto_err.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_sum    <= '0;
      pass_cnt    <= '0;
      fail_cnt    <= '0;
      timeout_err <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      if (take_start) begin
        pass_cnt    <= '0;
        fail_cnt    <= '0;
        timeout_err <= 1'b0;
        proto_err   <= 1'b0;
      end
      if (take_sum) begin
        last_sum <= eng.sum;
        if (sum_ok) pass_cnt <= sat_inc(pass_cnt);
        else        fail_cnt <= sat_inc(fail_cnt);
      end
      if (to_hit)    timeout_err <= 1'b1;
      if (stray_sum) proto_err   <= 1'b1;
    end
  end

endmodule
